// File: rtl/regs_sb_if.sv
// Register-file bus: two combinational read ports, one write port, scoreboard set and status.
interface regs_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] R_Addr_A;
  logic [ADDR_W-1:0] R_Addr_B;
  logic [DATA_W-1:0] R_Data_A;
  logic [DATA_W-1:0] R_Data_B;
  logic              R_Busy_A;
  logic              R_Busy_B;
  logic              Write_Reg;
  logic [ADDR_W-1:0] W_Addr;
  logic [DATA_W-1:0] W_Data;
  logic              Set_Busy;
  logic [ADDR_W-1:0] SB_Addr;
  logic              Busy_Any;
  logic              Ready;

  modport master (
    output R_Addr_A, R_Addr_B, Write_Reg, W_Addr, W_Data, Set_Busy, SB_Addr,
    input  R_Data_A, R_Data_B, R_Busy_A, R_Busy_B, Busy_Any, Ready
  );

  modport slave (
    input  R_Addr_A, R_Addr_B, Write_Reg, W_Addr, W_Data, Set_Busy, SB_Addr,
    output R_Data_A, R_Data_B, R_Busy_A, R_Busy_B, Busy_Any, Ready
  );
endinterface

// File: rtl/regs_sb.sv
// Parametrised register file with busy scoreboard; storage is cleared by a
// one-entry-per-cycle sweep after reset instead of a wide reset.
module regs_sb_rd #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              run,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              busy_q,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data,
  output logic              busy
);
  logic zero, hit;

  assign zero = ZERO_REG && (addr == '0);
  assign hit  = BYPASS && run && wr_en && (wr_addr == addr) && !zero;
  // A forwarded write also retires the pending result, so busy drops with it.
  assign data = (!run || zero) ? '0 : (hit ? wr_data : mem_q);
  assign busy = run && !hit && !zero && busy_q;
endmodule

module regs_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic     CLK,
  input logic     Reset,
  regs_sb_if.slave rf
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NRD   = 2;

  typedef enum logic {INIT, RUN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_idx, clr_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy, set_vec, clr_vec;
  logic              run, we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              w_zero, sb_zero;

  assign run     = (state == RUN);
  assign w_zero  = ZERO_REG && (rf.W_Addr == '0);
  assign sb_zero = ZERO_REG && (rf.SB_Addr == '0);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= INIT;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_nxt;
    end
  end

  // The sweep owns the write port during INIT; user writes are dropped.
  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_idx;
    we        = 1'b0;
    wa        = rf.W_Addr;
    wd        = rf.W_Data;
    case (state)
      INIT: begin
        we      = 1'b1;
        wa      = clr_idx;
        wd      = '0;
        clr_nxt = clr_idx + 1'b1;
        if (clr_idx == ADDR_W'(DEPTH-1)) state_nxt = RUN;
      end
      RUN: we = rf.Write_Reg && !w_zero;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (we && !Reset) mem[wa] <= wd;
  end

  // Set is OR-ed in after the clear so a same-edge set wins.
  assign set_vec = (run && rf.Set_Busy && !sb_zero) ? ({{(DEPTH-1){1'b0}}, 1'b1} << rf.SB_Addr) : '0;
  assign clr_vec = (run && rf.Write_Reg) ? ({{(DEPTH-1){1'b0}}, 1'b1} << rf.W_Addr) : '0;

  always_ff @(posedge CLK) begin
    if (Reset) busy <= '0;
    else       busy <= (busy & ~clr_vec) | set_vec;
  end

  logic [NRD-1:0][ADDR_W-1:0] rd_addr;
  logic [NRD-1:0][DATA_W-1:0] rd_data;
  logic [NRD-1:0]             rd_busy;

  assign rd_addr = {rf.R_Addr_B, rf.R_Addr_A};

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    regs_sb_rd #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG),
      .BYPASS  (BYPASS)
    ) u_rd (
      .run    (run),
      .addr   (rd_addr[p]),
      .mem_q  (mem[rd_addr[p]]),
      .busy_q (busy[rd_addr[p]]),
      .wr_en  (rf.Write_Reg),
      .wr_addr(rf.W_Addr),
      .wr_data(rf.W_Data),
      .data   (rd_data[p]),
      .busy   (rd_busy[p])
    );
  end

  assign rf.R_Data_A = rd_data[0];
  assign rf.R_Data_B = rd_data[1];
  assign rf.R_Busy_A = rd_busy[0];
  assign rf.R_Busy_B = rd_busy[1];
  assign rf.Busy_Any = run && (|busy);
  assign rf.Ready    = run;
endmodule

// File: tb/tb_regs_sb.sv
// Directed bench for regs_sb: one bypassing and one non-bypassing instance share stimulus.
module tb_regs_sb;
  logic        CLK = 1'b0;
  logic        Reset;
  logic [4:0]  r_addr_a, r_addr_b, w_addr, sb_addr;
  logic [31:0] w_data;
  logic        write_reg, set_busy;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 CLK = ~CLK;

  regs_sb_if #(.DATA_W(32), .ADDR_W(5)) i_b ();
  regs_sb_if #(.DATA_W(32), .ADDR_W(5)) i_n ();

  assign i_b.R_Addr_A = r_addr_a;  assign i_n.R_Addr_A = r_addr_a;
  assign i_b.R_Addr_B = r_addr_b;  assign i_n.R_Addr_B = r_addr_b;
  assign i_b.Write_Reg = write_reg; assign i_n.Write_Reg = write_reg;
  assign i_b.W_Addr = w_addr;      assign i_n.W_Addr = w_addr;
  assign i_b.W_Data = w_data;      assign i_n.W_Data = w_data;
  assign i_b.Set_Busy = set_busy;  assign i_n.Set_Busy = set_busy;
  assign i_b.SB_Addr = sb_addr;    assign i_n.SB_Addr = sb_addr;

  regs_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
    .CLK(CLK), .Reset(Reset), .rf(i_b.slave));
  regs_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
    .CLK(CLK), .Reset(Reset), .rf(i_n.slave));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ready();
    n = 0;
    while (!i_b.Ready && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    Reset = 1'b1; write_reg = 1'b0; set_busy = 1'b0;
    r_addr_a = 5'd5; r_addr_b = 5'd0; w_addr = '0; sb_addr = '0; w_data = '0;

    // reset state and sweep latency
    tick();
    Reset = 1'b0;
    #1;
    chk("rst_ready", 32'(i_b.Ready), 32'd0);
    chk("rst_busy_any", 32'(i_b.Busy_Any), 32'd0);
    chk("init_rdata_a", i_b.R_Data_A, 32'd0);
    chk("init_rbusy_a", 32'(i_b.R_Busy_A), 32'd0);
    wait_ready();
    chk("ready_latency", 32'(n), 32'd32);
    chk("ready_nb", 32'(i_n.Ready), 32'd1);

    // write then read both ports; zero register
    write_reg = 1'b1; w_addr = 5'd5; w_data = 32'hDEAD_BEEF;
    tick();
    write_reg = 1'b0; r_addr_a = 5'd5; r_addr_b = 5'd5;
    #1;
    chk("rd_a_x5", i_b.R_Data_A, 32'hDEAD_BEEF);
    chk("rd_b_x5", i_b.R_Data_B, 32'hDEAD_BEEF);
    chk("rd_b_x5_nb", i_n.R_Data_B, 32'hDEAD_BEEF);
    write_reg = 1'b1; w_addr = 5'd0; w_data = 32'd1; r_addr_a = 5'd0;
    #1;
    chk("x0_bypass", i_b.R_Data_A, 32'd0);
    tick();
    write_reg = 1'b0;
    #1;
    chk("x0_after", i_b.R_Data_A, 32'd0);

    // bypass vs no bypass
    write_reg = 1'b1; w_addr = 5'd7; w_data = 32'h1234; r_addr_a = 5'd7;
    #1;
    chk("byp_same", i_b.R_Data_A, 32'h1234);
    chk("nobyp_same", i_n.R_Data_A, 32'd0);
    tick();
    write_reg = 1'b0;
    #1;
    chk("nobyp_next", i_n.R_Data_A, 32'h1234);

    // scoreboard set and write-clear
    set_busy = 1'b1; sb_addr = 5'd9;
    tick();
    set_busy = 1'b0; r_addr_a = 5'd9;
    #1;
    chk("busy_x9", 32'(i_b.R_Busy_A), 32'd1);
    chk("busy_any_x9", 32'(i_b.Busy_Any), 32'd1);
    write_reg = 1'b1; w_addr = 5'd9; w_data = 32'd99;
    #1;
    chk("busy_x9_byp", 32'(i_b.R_Busy_A), 32'd0);
    chk("busy_x9_nb", 32'(i_n.R_Busy_A), 32'd1);
    chk("busy_any_pre", 32'(i_b.Busy_Any), 32'd1);
    tick();
    write_reg = 1'b0;
    #1;
    chk("busy_x9_clr", 32'(i_b.R_Busy_A), 32'd0);
    chk("busy_any_clr", 32'(i_b.Busy_Any), 32'd0);

    // same-edge set and write: set wins
    set_busy = 1'b1; sb_addr = 5'd3; write_reg = 1'b1; w_addr = 5'd3; w_data = 32'hAA;
    tick();
    set_busy = 1'b0; write_reg = 1'b0; r_addr_b = 5'd3;
    #1;
    chk("sw_data_x3", i_b.R_Data_B, 32'hAA);
    chk("sw_busy_x3", 32'(i_b.R_Busy_B), 32'd1);
    chk("sw_busy_any", 32'(i_b.Busy_Any), 32'd1);
    write_reg = 1'b1; w_data = 32'hBB;
    tick();
    write_reg = 1'b0; set_busy = 1'b1; sb_addr = 5'd0;
    tick();
    set_busy = 1'b0;
    #1;
    chk("x0_busy_drop", 32'(i_b.Busy_Any), 32'd0);
    chk("x3_rewrite", i_b.R_Data_B, 32'hBB);

    // reset mid-sweep discards state and restarts the sweep
    write_reg = 1'b1; w_addr = 5'd4; w_data = 32'd5;
    tick();
    write_reg = 1'b0; r_addr_a = 5'd4; set_busy = 1'b1; sb_addr = 5'd12;
    #1;
    chk("x4_run", i_b.R_Data_A, 32'd5);
    tick();
    set_busy = 1'b0; Reset = 1'b1;
    tick();
    Reset = 1'b0;
    #1;
    chk("rst2_busy_any", 32'(i_b.Busy_Any), 32'd0);
    chk("rst2_ready", 32'(i_b.Ready), 32'd0);
    repeat (10) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0; write_reg = 1'b1; w_addr = 5'd4; w_data = 32'd77;
    wait_ready();
    write_reg = 1'b0; r_addr_b = 5'd12;
    #1;
    chk("ready_latency2", 32'(n), 32'd32);
    chk("x4_cleared", i_b.R_Data_A, 32'd0);
    chk("x12_busy_gone", 32'(i_b.R_Busy_B), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
